// File: rtl/add_job_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_pkg
// Description : Shared state encoding and adder-slave register map for the
//               add_job_sequencer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package add_seq_pkg;

    // Controller states; ERROR is terminal until reset
    typedef enum logic [3:0] {
        ID_RD   = 4'd0,
        ID_WAIT = 4'd1,
        IDLE    = 4'd2,
        WR_A    = 4'd3,
        WR_B    = 4'd4,
        RD_C    = 4'd5,
        RD_WAIT = 4'd6,
        RESP    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    // Adder slave register map
    localparam logic [2:0] ADDR_A   = 3'd0;
    localparam logic [2:0] ADDR_B   = 3'd1;
    localparam logic [2:0] ADDR_SUM = 3'd2;
    localparam logic [2:0] ADDR_ID  = 3'd3;

endpackage
`default_nettype wire

// File: rtl/add_job_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant. Picks the first asserted
//               request at or after i_ptr, wrapping; pointer lives in parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic                       o_any,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
    output logic [NUM_REQ-1:0]         o_grant
);
    localparam int                 c_PTR_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Scan offsets from farthest to nearest so the nearest asserted request wins
    always_comb begin
        o_any       = 1'b0;
        o_grant_idx = '0;
        o_grant     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
                o_any       = 1'b1;
                o_grant_idx = c_PTR_W'((int'(i_ptr) + k) % NUM_REQ);
                o_grant     = c_ONE << ((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : add_job_sequencer
// Description : Avalon-MM master sharing one 32-bit adder slave between
//               NUM_REQ requesters. Per job: write A, write B, read sum,
//               return it. Verifies the slave ID once after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module add_job_sequencer
    import add_seq_pkg::*;
#(
    parameter int                NUM_REQ  = 2,
    parameter int                DATA_W   = 32,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'h12345678
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      id_error,
    output logic [15:0]               jobs_done,
    output logic [2:0]                avm_address,
    output logic                      avm_write,
    output logic                      avm_read,
    output logic [DATA_W-1:0]         avm_writedata,
    input  logic [DATA_W-1:0]         avm_readdata,
    input  logic                      avm_waitrequest
);
    localparam int                 c_PTR_W = $clog2(NUM_REQ);
    localparam int                 c_CNT_W = $clog2(READ_LAT + 1);
    localparam logic [NUM_REQ-1:0] c_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t               r_state, w_state_next;
    logic [c_PTR_W-1:0]   r_ptr, r_gnt_idx, w_gnt_idx;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [DATA_W-1:0]    r_a, r_b, w_sel_a, w_sel_b;
    logic [NUM_REQ-1:0]   w_gnt, r_req_ready, r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data, r_wdata, w_wdata_next;
    logic [2:0]           r_addr, w_addr_next;
    logic                 r_wr, r_rd, w_wr_next, w_rd_next;
    logic                 r_id_error;
    logic [15:0]          r_jobs;
    logic                 w_any, w_take, w_accept, w_wait_done;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_any       (w_any),
        .o_grant_idx (w_gnt_idx),
        .o_grant     (w_gnt)
    );

    assign w_sel_a     = req_a[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_sel_b     = req_b[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_take      = (r_state == IDLE) && w_any;
    // A strobe only counts once the slave has stopped stalling
    assign w_accept    = (r_wr || r_rd) && !avm_waitrequest;
    assign w_wait_done = (r_cnt == c_CNT_W'(READ_LAT - 1));

    // Next state plus next Avalon command; strobes are registered so they line up with the state
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            ID_RD:   if (w_accept) w_state_next = ID_WAIT;
            ID_WAIT: begin
                if (w_wait_done) w_state_next = (avm_readdata == ID_VALUE) ? IDLE : ERROR;
                else             w_cnt_next   = r_cnt + c_CNT_W'(1);
            end
            IDLE:    if (w_any) w_state_next = WR_A;
            WR_A:    if (w_accept) w_state_next = WR_B;
            WR_B:    if (w_accept) w_state_next = RD_C;
            RD_C:    if (w_accept) w_state_next = RD_WAIT;
            RD_WAIT: begin
                if (w_wait_done) w_state_next = RESP;
                else             w_cnt_next   = r_cnt + c_CNT_W'(1);
            end
            RESP:    w_state_next = IDLE;
            ERROR:   w_state_next = ERROR;
            default: w_state_next = ID_RD;
        endcase

        w_wr_next    = 1'b0;
        w_rd_next    = 1'b0;
        w_addr_next  = ADDR_A;
        w_wdata_next = '0;
        case (w_state_next)
            ID_RD:   begin w_rd_next = 1'b1; w_addr_next = ADDR_ID; end
            WR_A:    begin
                w_wr_next    = 1'b1;
                w_addr_next  = ADDR_A;
                // Operand is latched on the same edge that enters WR_A, so bypass it here
                w_wdata_next = (r_state == IDLE) ? w_sel_a : r_a;
            end
            WR_B:    begin w_wr_next = 1'b1; w_addr_next = ADDR_B; w_wdata_next = r_b; end
            RD_C:    begin w_rd_next = 1'b1; w_addr_next = ADDR_SUM; end
            default: ;
        endcase
    end

    // State, command and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ID_RD;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_id_error  <= 1'b0;
            r_jobs      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_wr        <= w_wr_next;
            r_rd        <= w_rd_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_req_ready <= w_take ? w_gnt : '0;
            r_rsp_valid <= (r_state == RESP) ? (c_ONE << r_gnt_idx) : '0;
            if (w_take) begin
                r_a       <= w_sel_a;
                r_b       <= w_sel_b;
                r_gnt_idx <= w_gnt_idx;
                r_ptr     <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + c_PTR_W'(1);
            end
            if (r_state == RD_WAIT && w_wait_done) r_rsp_data <= avm_readdata;
            if (r_state == RESP && r_jobs != 16'hFFFF) r_jobs <= r_jobs + 16'd1;
            if (r_state == ID_WAIT && w_wait_done && avm_readdata != ID_VALUE) r_id_error <= 1'b1;
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign busy          = (r_state != IDLE);
    assign id_error      = r_id_error;
    assign jobs_done     = r_jobs;
    assign avm_address   = r_addr;
    assign avm_write     = r_wr;
    assign avm_read      = r_rd;
    assign avm_writedata = r_wdata;

endmodule
`default_nettype wire
